// File: rtl/smem_row_sequencer.sv
// Gathers four DW-bit stream beats per SMEM row, hands each row to the row writer, and waits for the writer to drain.
// Optional SEQ_TLAST_CHECK_EN adds axis_in_tlast and a sticky tlast_err framing flag.
module smem_row_sequencer #(
  parameter int DW          = 512,
  parameter int DRAIN_DELAY = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   cfg_first_row,
  input  logic [31:0]   cfg_row_count,
  input  logic          go,
  output logic          busy,
  output logic          complete,
  output logic [31:0]   rows_written,
  input  logic [DW-1:0] axis_in_tdata,
  input  logic          axis_in_tvalid,
  output logic          axis_in_tready,
`ifdef SEQ_TLAST_CHECK_EN
  input  logic          axis_in_tlast,
  output logic          tlast_err,
`endif
  output logic [DW-1:0] smem_data0,
  output logic [DW-1:0] smem_data1,
  output logic [DW-1:0] smem_data2,
  output logic [DW-1:0] smem_data3,
  output logic [31:0]   row_index,
  output logic          start,
  input  logic          ready,
  input  logic          done
);

  localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_DELAY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_LAUNCH,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  beat_reg, beat_next;
  logic [31:0] remaining_reg, remaining_next;
  logic [7:0]  drain_reg, drain_next;
  logic [31:0] row_index_reg, row_index_next;
  logic [31:0] rows_written_reg, rows_written_next;
  logic        start_reg, start_next;
  logic        complete_reg, complete_next;

  logic beat_hs;
  logic go_accept;

  // A go on the complete cycle is dropped so the finishing job's pulse stays unambiguous.
  assign go_accept = (state_reg == S_IDLE) && go && !complete_reg;
  assign beat_hs   = (state_reg == S_COLLECT) && axis_in_tvalid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= S_IDLE;
      beat_reg         <= '0;
      remaining_reg    <= '0;
      drain_reg        <= '0;
      row_index_reg    <= '0;
      rows_written_reg <= '0;
      start_reg        <= 1'b0;
      complete_reg     <= 1'b0;
    end else begin
      state_reg        <= state_next;
      beat_reg         <= beat_next;
      remaining_reg    <= remaining_next;
      drain_reg        <= drain_next;
      row_index_reg    <= row_index_next;
      rows_written_reg <= rows_written_next;
      start_reg        <= start_next;
      complete_reg     <= complete_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    beat_next         = beat_reg;
    remaining_next    = remaining_reg;
    drain_next        = drain_reg;
    row_index_next    = row_index_reg;
    rows_written_next = rows_written_reg;
    start_next        = 1'b0;
    complete_next     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (go_accept) begin
          rows_written_next = '0;
          if (cfg_row_count != 32'd0) begin
            row_index_next = cfg_first_row;
            remaining_next = cfg_row_count;
            beat_next      = '0;
            state_next     = S_COLLECT;
          end else begin
            complete_next = 1'b1;
          end
        end
      end
      S_COLLECT: begin
        if (beat_hs) begin
          beat_next = beat_reg + 2'd1;
          if (beat_reg == 2'd3) state_next = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (ready) begin
          start_next        = 1'b1;
          rows_written_next = rows_written_reg + 32'd1;
          state_next        = S_WAIT;
        end
      end
      S_WAIT: begin
        // The writer drops ready in response to start; its ready is only meaningful afterwards.
        if (!start_reg && ready) begin
          remaining_next = remaining_reg - 32'd1;
          row_index_next = row_index_reg + 32'd1;
          if (remaining_reg == 32'd1) begin
            drain_next = DRAIN_LOAD;
            state_next = S_DRAIN;
          end else begin
            beat_next  = '0;
            state_next = S_COLLECT;
          end
        end
      end
      S_DRAIN: begin
        if (drain_reg != 8'd0) begin
          drain_next = drain_reg - 8'd1;
        end else if (done) begin
          complete_next = 1'b1;
          state_next    = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_seg
    logic [DW-1:0] seg_reg;
    always_ff @(posedge clk) begin
      if (reset) begin
        seg_reg <= '0;
      end else if (beat_hs && (beat_reg == 2'(gi))) begin
        seg_reg <= axis_in_tdata;
      end
    end
  end

`ifdef SEQ_TLAST_CHECK_EN
  logic tlast_err_reg;
  always_ff @(posedge clk) begin
    if (reset) begin
      tlast_err_reg <= 1'b0;
    end else if (go_accept) begin
      tlast_err_reg <= 1'b0;
    end else if (beat_hs && (axis_in_tlast != (beat_reg == 2'd3))) begin
      tlast_err_reg <= 1'b1;
    end
  end
  assign tlast_err = tlast_err_reg;
`endif

  assign busy           = (state_reg != S_IDLE);
  assign axis_in_tready = (state_reg == S_COLLECT);
  assign complete       = complete_reg;
  assign start          = start_reg;
  assign rows_written   = rows_written_reg;
  assign row_index      = row_index_reg;
  assign smem_data0     = g_seg[0].seg_reg;
  assign smem_data1     = g_seg[1].seg_reg;
  assign smem_data2     = g_seg[2].seg_reg;
  assign smem_data3     = g_seg[3].seg_reg;

endmodule

// File: tb/tb_smem_row_sequencer.sv
// Randomized bench for smem_row_sequencer: a row-level reference model is compared against the DUT every cycle,
// plus literal expectations for the directed scenarios.
module tb_smem_row_sequencer;
  localparam int DW = 512;
  localparam int DD = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   cfg_first_row = '0;
  logic [31:0]   cfg_row_count = '0;
  logic          go = 1'b0;
  logic          busy, complete, start, ready, axis_in_tready;
  logic [31:0]   rows_written, row_index;
  logic [DW-1:0] axis_in_tdata = '0;
  logic          axis_in_tvalid = 1'b0;
  logic [DW-1:0] smem_data0, smem_data1, smem_data2, smem_data3;
  logic          done = 1'b1;
`ifdef SEQ_TLAST_CHECK_EN
  logic          axis_in_tlast = 1'b0;
  logic          tlast_err;
`endif

  always #5 clk = ~clk;

  smem_row_sequencer #(.DW(DW), .DRAIN_DELAY(DD)) dut (
    .clk(clk), .reset(reset),
    .cfg_first_row(cfg_first_row), .cfg_row_count(cfg_row_count), .go(go),
    .busy(busy), .complete(complete), .rows_written(rows_written),
    .axis_in_tdata(axis_in_tdata), .axis_in_tvalid(axis_in_tvalid), .axis_in_tready(axis_in_tready),
`ifdef SEQ_TLAST_CHECK_EN
    .axis_in_tlast(axis_in_tlast), .tlast_err(tlast_err),
`endif
    .smem_data0(smem_data0), .smem_data1(smem_data1), .smem_data2(smem_data2), .smem_data3(smem_data3),
    .row_index(row_index), .start(start), .ready(ready), .done(done)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h, required %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- stimulus agents ----------------
  int   hold_cycles = 0;
  int   wr_cnt = 0;
  logic wr_rdy = 1'b1;
  always @(posedge clk) begin
    #1;
    if (reset) wr_cnt = 0;
    else if (start === 1'b1) wr_cnt = hold_cycles;
    else if (wr_cnt > 0) wr_cnt--;
    wr_rdy = (wr_cnt == 0);
  end
  assign ready = wr_rdy & ~start;

  bit   done_rand = 1'b0;
  logic done_level = 1'b1;
  always @(posedge clk) begin
    #2;
    done = done_rand ? 1'($urandom_range(0, 1)) : done_level;
  end

  bit          src_en = 1'b0;
  bit          src_gappy = 1'b0;
  logic [31:0] src_seq = 32'h0;
  bit          hs_seen = 1'b0;
  int          src_beat = 0;
`ifdef SEQ_TLAST_CHECK_EN
  bit          inj_tlast = 1'b0;
`endif
  always @(negedge clk) hs_seen = (axis_in_tvalid === 1'b1) && (axis_in_tready === 1'b1);
  always @(posedge clk) begin
    #1;
    if (reset) src_beat = 0;
    if (hs_seen) begin
`ifdef SEQ_TLAST_CHECK_EN
      if (src_beat == 1) inj_tlast = 1'b0;
`endif
      src_seq++;
      src_beat = (src_beat + 1) % 4;
      axis_in_tvalid = 1'b0;
    end
    if (!axis_in_tvalid && src_en && (!src_gappy || $urandom_range(0, 3) != 0)) axis_in_tvalid = 1'b1;
    axis_in_tdata = {(DW/32){src_seq}};
`ifdef SEQ_TLAST_CHECK_EN
    axis_in_tlast = (src_beat == 3) ^ (inj_tlast && src_beat == 1);
`endif
  end

  // ---------------- reference model + per-cycle compare ----------------
  bit            m_valid = 1'b0, m_active = 1'b0, m_launched = 1'b0, m_draining = 1'b0;
  int            m_beats = 0, m_drain_at = 0;
  logic [31:0]   m_left = '0;
  logic          e_busy = 0, e_complete = 0, e_start = 0, e_tready = 0, e_tlast_err = 0;
  logic [31:0]   e_rows_written = '0, e_row_index = '0;
  logic [DW-1:0] e_data [4];

  int            start_cnt = 0, complete_cnt = 0, start_cyc = 0, complete_cyc = 0, go_cyc = 0;
  bit            busy_seen = 1'b0;
  logic [31:0]   start_rows [$];
  logic [DW-1:0] cap_d [4];

  always @(negedge clk) begin
    logic n_start, n_complete;
    cyc++;
    if (m_valid) begin
      check("busy", busy, e_busy);
      check("complete", complete, e_complete);
      check("start", start, e_start);
      check("tready", axis_in_tready, e_tready);
      check("rows_written", rows_written, e_rows_written);
      check("row_index", row_index, e_row_index);
      check("smem_data0", smem_data0, e_data[0]);
      check("smem_data1", smem_data1, e_data[1]);
      check("smem_data2", smem_data2, e_data[2]);
      check("smem_data3", smem_data3, e_data[3]);
`ifdef SEQ_TLAST_CHECK_EN
      check("tlast_err", tlast_err, e_tlast_err);
`endif
    end
    if (start === 1'b1) begin
      start_cnt++; start_cyc = cyc; start_rows.push_back(row_index);
      cap_d[0] = smem_data0; cap_d[1] = smem_data1; cap_d[2] = smem_data2; cap_d[3] = smem_data3;
    end
    if (complete === 1'b1) begin complete_cnt++; complete_cyc = cyc; end
    if (busy === 1'b1) busy_seen = 1'b1;
    if (go === 1'b1) go_cyc = cyc;

    // Expectations for the next cycle, derived from this cycle's inputs.
    n_start = 1'b0; n_complete = 1'b0;
    if (reset) begin
      m_valid = 1'b1; m_active = 1'b0; m_launched = 1'b0; m_draining = 1'b0; m_beats = 0;
      e_rows_written = '0; e_row_index = '0; e_tlast_err = 1'b0;
      for (int i = 0; i < 4; i++) e_data[i] = '0;
    end else if (!m_active) begin
      if (go && !e_complete) begin
        e_rows_written = '0; e_tlast_err = 1'b0;
        if (cfg_row_count == 0) n_complete = 1'b1;
        else begin
          m_active = 1'b1; m_left = cfg_row_count; e_row_index = cfg_first_row;
          m_beats = 0; m_launched = 1'b0; m_draining = 1'b0;
        end
      end
    end else if (m_draining) begin
      if (cyc >= m_drain_at && done) begin n_complete = 1'b1; m_active = 1'b0; end
    end else if (m_beats < 4) begin
      if (axis_in_tvalid) begin
        e_data[m_beats] = axis_in_tdata;
`ifdef SEQ_TLAST_CHECK_EN
        if (axis_in_tlast != (m_beats == 3)) e_tlast_err = 1'b1;
`endif
        m_beats++;
      end
    end else if (!m_launched) begin
      if (ready) begin n_start = 1'b1; e_rows_written++; m_launched = 1'b1; end
    end else if (!e_start && ready) begin
      m_left--; e_row_index++;
      if (m_left == 0) begin m_draining = 1'b1; m_drain_at = cyc + 1 + DD; end
      else begin m_beats = 0; m_launched = 1'b0; end
    end
    e_start = n_start; e_complete = n_complete; e_busy = m_active;
    e_tready = m_active && !m_draining && (m_beats < 4);
  end

  // ---------------- directed + random sequences ----------------
  task automatic pulse_go(input logic [31:0] first, input logic [31:0] cnt);
    @(posedge clk); #1;
    cfg_first_row = first; cfg_row_count = cnt; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic wait_complete(input int bound, input string name);
    int n0 = complete_cnt;
    int k = 0;
    while (complete_cnt == n0 && k < bound) begin @(posedge clk); k++; end
    checks++;
    if (complete_cnt == n0) begin
      errors++;
      $display("FAIL %s: complete not seen within %0d cycles (required)", name, bound);
    end
    @(negedge clk);
  endtask

  initial begin : main
    int s0, c0, d_cyc;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_tready", axis_in_tready, 1'b0);
    check("reset_rows_written", rows_written, 32'd0);

    // Single row, data A..D, writer always ready, done high.
    src_seq = 32'hA; src_en = 1'b1; hold_cycles = 0;
    s0 = start_cnt;
    pulse_go(32'h10, 32'd1);
    wait_complete(500, "single_row");
    check("t1_starts", 32'(start_cnt - s0), 32'd1);
    check("t1_row_index", start_rows[start_rows.size()-1], 32'h10);
    check("t1_data0", cap_d[0], {(DW/32){32'hA}});
    check("t1_data1", cap_d[1], {(DW/32){32'hB}});
    check("t1_data2", cap_d[2], {(DW/32){32'hC}});
    check("t1_data3", cap_d[3], {(DW/32){32'hD}});
    check("t1_rows_written", rows_written, 32'd1);
    check("t1_drain_latency", 32'(complete_cyc - start_cyc), 32'(DD + 3));

    // Three rows across the index wrap with a slow writer; a go mid-job must be ignored.
    hold_cycles = 70; src_gappy = 1'b1;
    s0 = start_cnt; start_rows.delete();
    pulse_go(32'hFFFF_FFFF, 32'd3);
    repeat (30) @(posedge clk);
    pulse_go(32'h1234, 32'd9);
    wait_complete(2000, "multi_row");
    check("t2_starts", 32'(start_cnt - s0), 32'd3);
    check("t2_row0", start_rows[0], 32'hFFFF_FFFF);
    check("t2_row1", start_rows[1], 32'h0);
    check("t2_row2", start_rows[2], 32'h1);
    check("t2_rows_written", rows_written, 32'd3);
    hold_cycles = 0;

    // Zero count: complete on the next cycle, busy never seen; a go on the complete cycle is dropped.
    repeat (3) @(posedge clk);
    busy_seen = 1'b0; c0 = complete_cnt;
    @(posedge clk); #1;
    cfg_row_count = 32'd0; go = 1'b1;
    repeat (2) @(posedge clk);
    #1 go = 1'b0;
    repeat (5) @(negedge clk);
    check("t3_complete_count", 32'(complete_cnt - c0), 32'd1);
    check("t3_complete_latency", 32'(complete_cyc - (go_cyc - 1)), 32'd1);
    check("t3_busy_seen", 32'(busy_seen), 32'd0);

    // Done held low: complete must wait for done to rise.
    done_level = 1'b0; s0 = start_cnt; c0 = complete_cnt;
    pulse_go(32'h200, 32'd1);
    for (int k = 0; k < 300 && start_cnt == s0; k++) @(posedge clk);
    repeat (60) @(posedge clk);
    check("t4_no_early_complete", 32'(complete_cnt - c0), 32'd0);
    #1 done_level = 1'b1;
    d_cyc = cyc + 1;
    wait_complete(50, "done_rise");
    check("t4_complete_after_done", 32'(complete_cyc - d_cyc), 32'd1);

    // Reset while two beats of the first row are held.
    c0 = complete_cnt;
    pulse_go(32'h40, 32'd3);
    for (int k = 0; k < 300 && !(m_active && m_beats == 2 && !m_launched); k++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    repeat (40) @(negedge clk);
    check("t5_no_complete", 32'(complete_cnt - c0), 32'd0);
    check("t5_row_index", row_index, 32'd0);
    pulse_go(32'h80, 32'd2);
    wait_complete(800, "after_reset");
    check("t5_rows_written", rows_written, 32'd2);
    check("t5_final_row_index", row_index, 32'h82);

`ifdef SEQ_TLAST_CHECK_EN
    // Early tlast on beat 1 of row 0: flagged, row still written intact; next go clears it.
    @(posedge clk); #1 inj_tlast = 1'b1;
    pulse_go(32'h300, 32'd2);
    wait_complete(800, "tlast_job");
    check("t6_tlast_err_set", tlast_err, 1'b1);
    pulse_go(32'h400, 32'd1);
    @(negedge clk);
    check("t6_tlast_err_cleared", tlast_err, 1'b0);
    wait_complete(800, "tlast_clear_job");
`endif

    // Randomized jobs: random first row, count, writer hold, stream gaps and done jitter.
    for (int j = 0; j < 14; j++) begin
      logic [31:0] cnt;
      cnt = 32'($urandom_range(1, 4));
      hold_cycles = $urandom_range(0, 8);
      done_rand = ($urandom_range(0, 2) == 0);
      src_seq = $urandom;
      pulse_go($urandom, cnt);
      if (cnt > 1 && $urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(2, 10)) @(posedge clk);
        pulse_go($urandom, 32'($urandom_range(0, 5)));
      end
      wait_complete(3000, "random_job");
      done_rand = 1'b0;
      repeat (2) @(posedge clk);
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation did not end within time limit, %0d errors so far", errors);
    $fatal(1, "watchdog");
  end

endmodule
